// File: rtl/aes_pkg.sv
// Shared AES-128 constants, output payload type, Rcon table and S-box helpers
// for the AddRoundKey stage.
package aes_pkg;

    localparam int unsigned STATE_W   = 128;
    localparam int unsigned KEY_W     = 128;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned RND_W     = 4;
    localparam int unsigned NR_AES128 = 10;

    // One result leaving the stage: state XOR round key, plus its round tag
    typedef struct packed {
        logic [STATE_W-1:0] data;
        logic [RND_W-1:0]   round;
        logic               last;
    } ark_out_t;

    // Forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // (255 - b) * 8 is {~b, 3'b000}
    function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: BYTE_W];
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for rounds 1..10; anything else yields zero
    function automatic logic [BYTE_W-1:0] rcon(input logic [RND_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the current
// one and its round constant, purely combinationally.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0]  rk_i,
    input  logic [BYTE_W-1:0] rcon_i,
    output logic [KEY_W-1:0]  rk_next_c_o
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] n0, n1, n2, n3;
    logic [WORD_W-1:0] tmp;

    always_comb begin
        {w0, w1, w2, w3} = rk_i;
        tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h000000};
        n0  = w0 ^ tmp;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        rk_next_c_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_add_round_key.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion and valid/ready
// handshake. Define AES_ARK_SKID_EN for a 2-entry output skid buffer.
module aes_add_round_key
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_load,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic [RND_W-1:0]   out_round,
    output logic               out_last
);

    logic [KEY_W-1:0]  key_q, key_d;
    logic [KEY_W-1:0]  rk_q, rk_d;
    logic [KEY_W-1:0]  rk_step;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [BYTE_W-1:0] rcon_c;
    logic              xfer_c;
    logic              rnd_last_c;
    ark_out_t          res_c;

    assign xfer_c     = in_valid && in_ready;
    assign rnd_last_c = (rnd_q == RND_W'(NR));
    assign rcon_c     = rcon(rnd_q + 4'd1);
    assign res_c      = '{data: in_data ^ rk_q, round: rnd_q, last: rnd_last_c};

    aes_key_step u_key_step (
        .rk_i        (rk_q),
        .rcon_i      (rcon_c),
        .rk_next_c_o (rk_step)
    );

    // Key schedule: advance per accepted block round, wrap to cipher key after NR
    always_comb begin
        key_d = key_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        if (key_load) begin
            key_d = key_in;
            rk_d  = key_in;
            rnd_d = '0;
        end else if (xfer_c) begin
            if (rnd_last_c) begin
                rk_d  = key_q;
                rnd_d = '0;
            end else begin
                rk_d  = rk_step;
                rnd_d = rnd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
        end else begin
            key_q <= key_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_d;
        end
    end

`ifdef AES_ARK_SKID_EN
    ark_out_t   ent_q [2];
    ark_out_t   ent_d [2];
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;
    logic       pop_c;

    // Ready is registered so it never depends on out_ready combinationally
    assign in_ready  = rdy_q && !key_load;
    assign out_valid = (cnt_q != 2'd0);
    assign pop_c     = out_valid && out_ready;
    assign out_data  = ent_q[0].data;
    assign out_round = ent_q[0].round;
    assign out_last  = ent_q[0].last;

    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        cnt_d    = cnt_q;
        if (key_load) begin
            cnt_d = 2'd0;
        end else begin
            if (pop_c) begin
                ent_d[0] = ent_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            if (xfer_c) begin
                if (cnt_d == 2'd0) begin
                    ent_d[0] = res_c;
                end else begin
                    ent_d[1] = res_c;
                end
                cnt_d = cnt_d + 2'd1;
            end
        end
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b1;
        end else begin
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
        end
    end
`else
    ark_out_t out_q, out_d;
    logic     vld_q, vld_d;

    assign in_ready  = !key_load && (!vld_q || out_ready);
    assign out_valid = vld_q;
    assign out_data  = out_q.data;
    assign out_round = out_q.round;
    assign out_last  = out_q.last;

    // Single output register; key_load drops any pending result
    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        if (key_load) begin
            vld_d = 1'b0;
        end else if (xfer_c) begin
            out_d = res_c;
            vld_d = 1'b1;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end
`endif

endmodule

// File: tb/tb_aes_add_round_key.sv
// Directed bench for aes_add_round_key: FIPS-197 key schedule, throughput,
// backpressure, key reload and mid-block reset.
module tb_aes_add_round_key;

    logic         clk;
    logic         rst_n;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_last;

    int checks = 0;
    int errors = 0;
    logic [127:0] rk_a [0:10];
    logic         skid;

    aes_add_round_key #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_round (out_round),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Round keys of cipher key 000102..0f
        rk_a[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_a[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_a[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_a[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_a[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_a[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_a[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_a[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_a[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_a[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_a[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`ifdef AES_ARK_SKID_EN
        skid = 1'b1;
`else
        skid = 1'b0;
`endif

        rst_n = 1'b0; key_load = 1'b0; key_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_data",  out_data, 128'd0);
        chk("rst_round", 128'(out_round), 128'd0);
        chk("rst_last",  128'(out_last), 128'd0);

        // Zero key before any key_load
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = '0;
        #1 chk("zk_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        chk("zk0_valid", 128'(out_valid), 128'd1);
        chk("zk0_data",  out_data, 128'd0);
        chk("zk0_round", 128'(out_round), 128'd0);
        @(negedge clk);
        chk("zk1_data",  out_data, 128'h62636363626363636263636362636363);
        chk("zk1_round", 128'(out_round), 128'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 128'(out_valid), 128'd0);

        // key_load has priority over a pending transfer
        key_load = 1'b1; key_in = rk_a[0];
        in_valid = 1'b1; in_data = 128'h00112233445566778899aabbccddeeff;
        #1 chk("kl_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        chk("kl_valid", 128'(out_valid), 128'd0);
        key_load = 1'b0;
        @(negedge clk);
        chk("r0_data",  out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("r0_round", 128'(out_round), 128'd0);
        chk("r0_last",  128'(out_last), 128'd0);
        in_data = '0;

        // Back-to-back rounds 1..10, then wrap to the cipher key
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            chk("bb_valid", 128'(out_valid), 128'd1);
            chk("bb_data",  out_data, rk_a[r]);
            chk("bb_round", 128'(out_round), 128'(r));
            chk("bb_last",  128'(out_last), (r == 10) ? 128'd1 : 128'd0);
        end
        @(negedge clk);
        chk("wrap_data",  out_data, rk_a[0]);
        chk("wrap_round", 128'(out_round), 128'd0);
        chk("wrap_last",  128'(out_last), 128'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_drain", 128'(out_valid), 128'd0);

        // Backpressure: hold out_ready low for five cycles
        out_ready = 1'b0; in_valid = 1'b1; in_data = '0;
        #1 chk("st_ready0", 128'(in_ready), 128'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("st_valid", 128'(out_valid), 128'd1);
            chk("st_data",  out_data, rk_a[1]);
            chk("st_round", 128'(out_round), 128'd1);
            chk("st_ready", 128'(in_ready), (skid && k == 0) ? 128'd1 : 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_data2",  out_data, rk_a[2]);
        chk("rel_round2", 128'(out_round), 128'd2);
        @(negedge clk);
        chk("rel_data3",  out_data, rk_a[3]);
        chk("rel_round3", 128'(out_round), 128'd3);

        // New key loaded at round 4 while in_valid is high
        key_load = 1'b1; key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        #1 chk("kl4_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        chk("kl4_valid", 128'(out_valid), 128'd0);
        key_load = 1'b0;
        @(negedge clk);
        chk("nk0_data",  out_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("nk0_round", 128'(out_round), 128'd0);
        @(negedge clk);
        chk("nk1_data",  out_data, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("nk1_round", 128'(out_round), 128'd1);

        // Asynchronous reset mid-block
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_valid", 128'(out_valid), 128'd0);
        chk("mr_data",  out_data, 128'd0);
        chk("mr_round", 128'(out_round), 128'd0);
        chk("mr_last",  128'(out_last), 128'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_data = '0;
        @(negedge clk);
        chk("pr0_valid", 128'(out_valid), 128'd1);
        chk("pr0_data",  out_data, 128'd0);
        chk("pr0_round", 128'(out_round), 128'd0);
        @(negedge clk);
        chk("pr1_data",  out_data, 128'h62636363626363636263636362636363);
        chk("pr1_round", 128'(out_round), 128'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pr_drain", 128'(out_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
